// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that shares one UART transmitter byte
// interface among NUM_REQ byte-stream requesters, with a FETCH stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_active,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [19:0]       to_cnt;
  logic              last_flag;

  logic [ID_W-1:0]   pick;
  logic              pick_ok;
  logic [NUM_REQ-1:0] gnt_mask;
  logic [7:0]        sel_byte;
  logic              sel_valid;
  logic              sel_last;

  // Scan upward from last_grant+1 so the most recent grantee ranks lowest.
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!pick_ok && (j == idx) && req_valid[j]) begin
          pick    = ID_W'(j);
          pick_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_mask = '0;
    sel_byte = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(grant_id) == k) begin
        gnt_mask[k] = 1'b1;
        sel_byte    = req_data[8*k +: 8];
      end
    end
  end

  assign sel_valid = |(req_valid & gnt_mask);
  assign sel_last  = |(req_last & gnt_mask);
  assign req_ready = (state == FETCH) ? gnt_mask : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      timeout_err  <= 1'b0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      to_cnt       <= '0;
      last_flag    <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
            to_cnt       <= '0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (sel_valid) begin
            tx_data   <= sel_byte;
            last_flag <= sel_last;
            tx_start  <= 1'b1;
            state     <= START;
          end else if (to_cnt == TO_LAST) begin
            timeout_err  <= 1'b1;
            last_grant   <= grant_id;
            grant_active <= 1'b0;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + 20'd1;
          end
        end
        START: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_flag) begin
              last_grant   <= grant_id;
              grant_active <= 1'b0;
              state        <= IDLE;
            end else begin
              to_cnt <= '0;
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: lane drivers, a 10-cycle transmitter model,
// a packet-level round-robin scoreboard and hand-computed timing expectations.
module tb_uart_tx_arbiter;
  localparam int NR   = 4;
  localparam int BUSY = 10;

  logic            clock;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            grant_active;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .grant_active(grant_active), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] lb [NR][8];
  bit         ll [NR][8];
  int lsize [NR];
  int lim   [NR];
  int sent  [NR];
  int lstart[NR];
  bit lane_en = 1'b0;

  exp_t exp_q[$];
  int   exp_to;

  int hs_cnt[NR], stall_cnt[NR], first_rdy[NR], ls[NR];
  int first_valid, first_start, fall_cyc, to_seen, to_cyc, n_start;
  logic [1:0] id_log[$];
  logic [7:0] data_log[$];
  bit prev_start, prev_ga;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NR; i++) begin
      hs_cnt[i] = 0; stall_cnt[i] = 0; first_rdy[i] = -1; ls[i] = -1;
    end
    first_valid = -1; first_start = -1; fall_cyc = -1;
    to_seen = 0; to_cyc = -1; n_start = 0;
    id_log.delete();
    data_log.delete();
  endtask

  task automatic set_lane(input int i, input int n, input int l,
                          input logic [63:0] b, input logic [7:0] lm);
    lsize[i] = n;
    lim[i]   = l;
    for (int k = 0; k < 8; k++) begin
      lb[i][k] = b[8*k +: 8];
      ll[i][k] = lm[k];
    end
  endtask

  // Packet-level round robin: serve whole packets, a lane that runs dry mid-packet times out.
  task automatic build_model();
    int pos[NR];
    int avail[NR];
    int last, g;
    bit found, done;
    exp_t e;
    exp_q.delete();
    exp_to = 0;
    last = NR - 1;
    g = 0;
    for (int i = 0; i < NR; i++) begin
      pos[i]   = 0;
      avail[i] = (lim[i] < lsize[i]) ? lim[i] : lsize[i];
    end
    for (int it = 0; it < 64; it++) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && pos[(last + k) % NR] < avail[(last + k) % NR]) begin
          g = (last + k) % NR;
          found = 1'b1;
        end
      end
      if (!found) break;
      done = 1'b0;
      while (!done && pos[g] < avail[g]) begin
        e.id = g[1:0];
        e.d  = lb[g][pos[g]];
        exp_q.push_back(e);
        done = ll[g][pos[g]];
        pos[g]++;
      end
      if (!done) exp_to++;
      last = g;
    end
  endtask

  task automatic begin_scn();
    @(negedge clock); #2;
    rst_n   = 1'b0;
    lane_en = 1'b0;
    for (int i = 0; i < NR; i++) begin
      lsize[i] = 0; lim[i] = 0; sent[i] = 0; lstart[i] = 0;
    end
    exp_q.delete();
    clear_stats();
    repeat (2) @(negedge clock);
    #2;
  endtask

  task automatic go();
    build_model();
    rst_n = 1'b1;
    @(negedge clock); #2;
    lane_en = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !grant_active && !tx_busy) && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    check({name, "_completes"}, 32'(n < 3000), 1);
    repeat (3) @(negedge clock);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_timeouts"}, to_seen, exp_to);
  endtask

  // Environment: lane drivers and transmitter model, driven 1 time unit after the edge.
  initial begin : env
    logic [NR-1:0] hs;
    int bcnt;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0; bcnt = 0;
    forever begin
      @(negedge clock);
      hs = req_valid & req_ready;
      @(posedge clock); #1;
      if (!rst_n) begin
        tx_busy = 1'b0;
        bcnt    = 0;
      end else if (tx_start) begin
        tx_busy = 1'b1;
        bcnt    = BUSY;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) sent[i]++;
        if (lane_en && cyc >= lstart[i] && sent[i] < lim[i] && sent[i] < lsize[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = lb[i][sent[i]];
          req_last[i]        = ll[i][sent[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = '0;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, checked mid-cycle.
  initial begin : cmp
    logic [NR-1:0] allowed;
    exp_t e;
    prev_start = 1'b0;
    prev_ga    = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_ga    = 1'b0;
        continue;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) hs_cnt[i]++;
        if (req_ready[i] && !req_valid[i]) stall_cnt[i]++;
        if (req_ready[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
      end
      if (req_valid != '0 && first_valid < 0) first_valid = cyc;
      allowed = grant_active ? (4'b0001 << grant_id) : 4'b0000;
      check("ready_only_grantee", 32'(req_ready & ~allowed), 0);
      if (tx_start) begin
        check("start_single_cycle", 32'(prev_start), 0);
        check("start_while_granted", 32'(grant_active), 1);
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.d));
          check("grant_id_at_start", 32'(grant_id), 32'(e.id));
        end
        n_start++;
        if (first_start < 0) first_start = cyc;
        ls[int'(grant_id)] = cyc;
        id_log.push_back(grant_id);
        data_log.push_back(tx_data);
      end
      if (prev_ga && !grant_active) fall_cyc = cyc;
      if (timeout_err) begin
        to_seen++;
        to_cyc = cyc;
      end
      prev_start = tx_start;
      prev_ga    = grant_active;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst_n = 1'b0;

    // Single requester, 3-byte packet.
    begin_scn();
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_grant_active", 32'(grant_active), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    set_lane(0, 3, 3, 64'h0F3CA5, 8'b100);
    go();
    wait_done("sc1");
    check("sc1_latency", first_start - first_valid, 2);
    check("sc1_accepts", hs_cnt[0], 3);
    check("sc1_stalls", stall_cnt[0], 0);
    check("sc1_release", fall_cyc - ls[0], 11);
    check("sc1_nstarts", n_start, 3);
    check("sc1_byte0", 32'(data_log[0]), 32'hA5);
    check("sc1_byte1", 32'(data_log[1]), 32'h3C);
    check("sc1_byte2", 32'(data_log[2]), 32'h0F);

    // Requesters 0 and 2 raise valid together.
    begin_scn();
    set_lane(0, 1, 1, 64'h11, 8'b1);
    set_lane(2, 1, 1, 64'h22, 8'b1);
    go();
    wait_done("sc2");
    check("sc2_first_id", 32'(id_log[0]), 0);
    check("sc2_second_id", 32'(id_log[1]), 2);
    check("sc2_second_byte", 32'(data_log[1]), 32'h22);
    check("sc2_grant_latency", first_rdy[0] - first_valid, 1);
    check("sc2_regrant_gap", first_rdy[2] - ls[0], 12);

    // All four lanes streaming two 2-byte packets each.
    begin_scn();
    for (int i = 0; i < NR; i++)
      set_lane(i, 4, 4, {32'h0, 8'(i*16+3), 8'(i*16+2), 8'(i*16+1), 8'(i*16)}, 8'b1010);
    go();
    wait_done("sc3");
    check("sc3_nstarts", n_start, 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("sc3_id_seq%0d", k), 32'(id_log[k]), 32'((k / 2) % 4));

    // Requester 1 stalls after its first byte; requester 3 pending.
    begin_scn();
    set_lane(1, 2, 1, 64'h3231, 8'b10);
    set_lane(3, 1, 1, 64'h71, 8'b1);
    go();
    wait_done("sc4");
    check("sc4_timeouts", to_seen, 1);
    check("sc4_timeout_time", to_cyc - ls[1], 27);
    check("sc4_fetch_stalls", stall_cnt[1], 16);
    check("sc4_next_grant", first_rdy[3] - to_cyc, 1);
    check("sc4_id0", 32'(id_log[0]), 1);
    check("sc4_id1", 32'(id_log[1]), 3);

    // Reset during WAIT_DONE of a 3-byte packet.
    begin_scn();
    set_lane(2, 3, 3, 64'h838281, 8'b100);
    go();
    n = 0;
    while (n_start < 2 && n < 500) begin
      @(negedge clock); #1;
      n++;
    end
    check("sc5_reached_byte2", 32'(n < 500), 1);
    repeat (4) @(negedge clock);
    #2;
    check("sc5_pre_grant_id", 32'(grant_id), 2);
    check("sc5_pre_grant_active", 32'(grant_active), 1);
    rst_n = 1'b0;
    #1;
    check("sc5_async_tx_start", 32'(tx_start), 0);
    check("sc5_async_tx_data", 32'(tx_data), 0);
    check("sc5_async_grant_id", 32'(grant_id), 0);
    check("sc5_async_grant_active", 32'(grant_active), 0);
    check("sc5_async_timeout_err", 32'(timeout_err), 0);
    check("sc5_async_req_ready", 32'(req_ready), 0);
    begin_scn();
    set_lane(0, 1, 1, 64'h91, 8'b1);
    set_lane(2, 1, 1, 64'hA1, 8'b1);
    go();
    wait_done("sc5");
    check("sc5_first_id", 32'(id_log[0]), 0);
    check("sc5_first_byte", 32'(data_log[0]), 32'h91);
    check("sc5_second_id", 32'(id_log[1]), 2);

    // Requester 1 raises valid during requester 0's 4-byte packet.
    begin_scn();
    set_lane(0, 4, 4, 64'hB3B2B1B0, 8'b1000);
    set_lane(1, 1, 1, 64'hC0, 8'b1);
    lstart[1] = 32'h3FFF_FFFF;
    go();
    lstart[1] = cyc + 8;
    wait_done("sc6");
    check("sc6_nstarts", n_start, 5);
    for (int k = 0; k < 4; k++)
      check($sformatf("sc6_pkt0_id%0d", k), 32'(id_log[k]), 0);
    check("sc6_pkt1_id", 32'(id_log[4]), 1);
    check("sc6_grant_after_release", first_rdy[1] - ls[0], 12);
    check("sc6_lane1_accepts", hs_cnt[1], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface (tx_data / tx_start / tx_busy) among NUM_REQ byte-stream requesters.
- Grants are round-robin and packet-atomic: a grant is held until the requester's byte marked last has finished transmitting.
- A stalled requester loses its grant after TIMEOUT_CYCLES.
- Sits between on-chip protocol engines and the UART TX serializer, alongside the usart_rx receive path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 50000, idle clocks allowed in FETCH before the grant is revoked.

Ports:
- clock, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, requester i has a byte on its data lane.
- req_data, input, NUM_REQ*8, byte lanes; lane i is bits [8i+7:8i].
- req_last, input, NUM_REQ, lane i's byte is the final byte of its packet.
- req_ready, output, NUM_REQ, byte accepted from lane i on this cycle when valid is also high.
- tx_data, output, 8, byte presented to the UART transmitter.
- tx_start, output, 1, single-cycle pulse that starts transmission of tx_data.
- tx_busy, input, 1, transmitter is serializing a byte.
- grant_id, output, ID_W, index of the current or most recent grantee.
- grant_active, output, 1, a packet grant is held.
- timeout_err, output, 1, single-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state = IDLE
  - tx_start = 0, tx_data = 8'h00
  - grant_id = 0, grant_active = 0, timeout_err = 0
  - req_ready = 0
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - timeout counter = 0
- State machine (registered): IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid bit is set, choose the first set index scanning upward from last_grant+1, modulo NUM_REQ.
  - Register that index into grant_id, set grant_active=1, clear the timeout counter, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - req_ready[grant_id] = 1 combinationally; all other req_ready bits = 0.
  - If req_valid[grant_id] = 1: latch req_data lane into tx_data and req_last into last_flag, then go to START.
  - Else increment the timeout counter. When it reaches TIMEOUT_CYCLES-1: pulse timeout_err for one cycle, set last_grant = grant_id, clear grant_active, go to IDLE.
- START: tx_start = 1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy = 0.
  - If last_flag = 1: set last_grant = grant_id, clear grant_active, go to IDLE.
  - Otherwise clear the timeout counter and return to FETCH.
- req_ready is 0 in every state except FETCH.
- Latency:
  - Request seen in IDLE at cycle N: accept occurs at N+1 and tx_start pulses at N+2.
  - Between bytes of one packet: tx_busy falling (observed in WAIT_DONE) gives FETCH on the next cycle; tx_start follows 1 cycle after the accept.
- tx_data is held stable from accept until the next accept. grant_id holds its value after the grant is released.
- Packet atomicity: req_valid on other lanes is ignored while grant_active = 1.
- Simultaneous events:
  - A requester asserting valid in the same cycle as a release is arbitrated in the following IDLE cycle.
  - The just-released requester has lowest priority in that arbitration.
- Changes to a requester's req_valid or data while it is not granted have no effect.
- A grantee dropping req_valid mid-packet is covered by the FETCH timeout.
- Reset mid-operation: all state clears immediately and tx_start is forced to 0. Any partially sent packet is abandoned; the transmitter is not notified.
- Widths:
  - Timeout counter is 20 bits and saturates at TIMEOUT_CYCLES-1; it never wraps.
  - The round-robin pointer wraps from NUM_REQ-1 to 0.

Test Plan:
- Single requester, 3 bytes (A5, 3C, 0F last); transmitter model holds busy for 10 cycles per byte -> three tx_start pulses carrying A5, 3C, 0F; grant_active falls after the third busy falls; req_ready[0] high exactly 3 cycles with valid.
- Requesters 0 and 2 both raise valid in the same cycle after reset, 1-byte packets -> requester 0 is served first (grant_id=0), then grant_id=2; no interleaving of their bytes.
- All 4 requesters continuously sending 2-byte packets -> grant_id sequence is 0, 1, 2, 3, 0, ...; every packet is contiguous on tx_start.
- Requester 1 sends its first byte, then drops valid, with TIMEOUT_CYCLES=16 -> timeout_err pulses exactly 16 FETCH cycles later; grant releases; requester 3 (pending) is granted next.
- rst_n asserted during WAIT_DONE of a 3-byte packet -> all outputs return to reset values asynchronously; after release, requester 0 (if valid) is granted first.
- Requester 1 holds valid during requester 0's 4-byte packet -> req_ready[1] stays 0 throughout; requester 1 is granted in the IDLE cycle after requester 0's last busy falls.
